layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
Top-level frame scheduler for the LeNet accelerator. It accepts a one-cycle frame start and sequences the convolution engine (conv1 then conv2) and then the fully-connected engine, using start-pulse/done-pulse handshakes. A per-state watchdog detects hung engines or out-of-order completion. Frame and cycle counters provide performance visibility.

Parameters:
TIMEOUT_CYCLES, 1000000, maximum cycles spent in any single wait state before error; must satisfy 2 <= value <= 2^TIMEOUT_W
TIMEOUT_W, 20, width of the wait-cycle counter
CYC_W, 24, width of the frame cycle counter and last_frame_cycles
FRAME_W, 16, width of frame_cnt

Ports:
clk  input  1  clock
srst  input  1  synchronous reset, active-high
start  input  1  frame start request, one-cycle pulse
clear_err  input  1  leave ERR state
conv_start  output  1  one-cycle start pulse to convolution engine
conv1_done  input  1  conv1 layer finished, pulse
conv_done  input  1  conv2 layer finished, pulse
fc_start  output  1  one-cycle start pulse to FC engine
fc_done  input  1  FC layer finished, pulse
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, frame complete
err  output  1  high while in ERR
err_code  output  2  0 none, 1 timeout, 2 ordering violation
state  output  3  current state encoding (debug)
frame_cnt  output  FRAME_W  frames completed, wraps to 0
last_frame_cycles  output  CYC_W  cycle count of last completed frame

Behaviour:
- Reset (srst=1 at a clock edge): state=IDLE; all outputs 0; all counters 0. Reset overrides every other event, including mid-frame.
- All outputs are registered or decoded from the state register; no combinational input-to-output paths.
- States: IDLE=0, CONV_KICK=1, CONV1_WAIT=2, CONV2_WAIT=3, FC_KICK=4, FC_WAIT=5, DONE=6, ERR=7.
- IDLE: start=1 -> CONV_KICK; cyc_cnt cleared to 0.
- CONV_KICK: conv_start=1 for exactly this cycle; next state is CONV1_WAIT unconditionally. Done inputs are ignored in this cycle.
- CONV1_WAIT: conv1_done -> CONV2_WAIT. conv_done or fc_done (including when simultaneous with conv1_done) -> ERR with err_code=2.
- CONV2_WAIT: conv_done -> FC_KICK. conv1_done or fc_done -> ERR with err_code=2.
- FC_KICK: fc_start=1 for exactly this cycle; next state is FC_WAIT unconditionally. Done inputs are ignored.
- FC_WAIT: fc_done -> DONE, and last_frame_cycles <= cyc_cnt+1 in the same edge. conv1_done or conv_done -> ERR with err_code=2.
- DONE: done=1 for this cycle; frame_cnt increments (wraps modulo 2^FRAME_W); next state is IDLE.
- ERR: err=1; err_code is held; busy=1. clear_err -> IDLE and err_code cleared. start is ignored in ERR.
- start is ignored in every state except IDLE. No queuing.
- Done pulses arriving in IDLE or DONE are ignored.
- cyc_cnt increments every cycle while state is not IDLE and not ERR. It saturates at 2^CYC_W-1.
- wait_cnt is cleared on entry to each of CONV1_WAIT, CONV2_WAIT and FC_WAIT, and increments each cycle in those states.
- Timeout: if wait_cnt == TIMEOUT_CYCLES-1 and the expected done is absent -> ERR with err_code=1. An expected done arriving in that same cycle wins.
- Ordering violations take priority over timeout in the same cycle.
- conv_start and fc_start are never high in the same cycle and never high for more than one cycle per frame.

Test Plan:
- Nominal frame: start at cycle 0; conv1_done at cycle 2; conv_done at cycle 3; fc_done at cycle 5 -> conv_start high at cycle 1, fc_start high at cycle 4, done high at cycle 6, last_frame_cycles=5, frame_cnt=1, state=IDLE at cycle 7.
- Timeout, TIMEOUT_CYCLES=8: start, then conv1_done withheld -> ERR entered after 8 CONV1_WAIT cycles with err=1 and err_code=1. A start pulse in ERR has no effect. clear_err returns to IDLE with err_code=0.
- Timeout boundary, TIMEOUT_CYCLES=8: conv_done asserted on the 8th CONV2_WAIT cycle -> FC_KICK, no error.
- Ordering: in CONV1_WAIT, assert conv1_done and conv_done together -> ERR with err_code=2; fc_start never asserted.
- Ignored inputs: start pulses during CONV2_WAIT and fc_done pulses in IDLE -> no extra conv_start, frame_cnt unchanged.
- Reset mid-frame: srst during FC_WAIT -> next cycle state=0, busy=0, frame_cnt=0, last_frame_cycles=0. A following normal frame completes with frame_cnt=1.
- Wrap: run with FRAME_W=2 for 5 frames -> frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: frame scheduler for the LeNet accelerator.
// Runs conv1 -> conv2 -> FC with start/done pulse handshakes,
// a per-wait-state watchdog and frame/cycle performance counters.
//
// Ports:
//   clk, srst           clock, synchronous active-high reset
//   start               frame start request (pulse, honoured in IDLE)
//   clear_err           leave the ERR state
//   conv_start          start pulse to the convolution engine
//   conv1_done          conv1 layer finished (pulse)
//   conv_done           conv2 layer finished (pulse)
//   fc_start            start pulse to the FC engine
//   fc_done             FC layer finished (pulse)
//   busy                state != IDLE
//   done                frame complete (pulse)
//   err, err_code       error flag; code 1 timeout, 2 ordering
//   state               current state (debug)
//   frame_cnt           completed frames, wrapping
//   last_frame_cycles   cycle count of the last completed frame

module layer_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20,
    parameter int CYC_W          = 24,
    parameter int FRAME_W        = 16
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic               clear_err,
    output logic               conv_start,
    input  logic               conv1_done,
    input  logic               conv_done,
    output logic               fc_start,
    input  logic               fc_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [2:0]         state,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [CYC_W-1:0]   last_frame_cycles
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CONV_KICK  = 3'd1,
        S_CONV1_WAIT = 3'd2,
        S_CONV2_WAIT = 3'd3,
        S_FC_KICK    = 3'd4,
        S_FC_WAIT    = 3'd5,
        S_DONE       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;

    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_err_code;
    logic [1:0]           w_err_code_next;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic [CYC_W-1:0]     r_cyc_cnt;
    logic [CYC_W-1:0]     w_cyc_inc;
    logic [FRAME_W-1:0]   r_frame_cnt;
    logic [CYC_W-1:0]     r_last_cycles;
    logic                 w_in_wait;
    logic                 w_timeout;

    assign w_in_wait = (r_state == S_CONV1_WAIT) ||
                       (r_state == S_CONV2_WAIT) ||
                       (r_state == S_FC_WAIT);

    assign w_timeout = (r_wait_cnt == TO_LAST);

    // Saturating increment, shared by the counter and the
    // last_frame_cycles capture so both see the same value.
    assign w_cyc_inc = (r_cyc_cnt == CYC_MAX) ?
                       r_cyc_cnt : r_cyc_cnt + CYC_W'(1);

    // In each wait state: ordering violation first, then the
    // expected done, then timeout (so a late done still wins).
    always_comb begin
        w_next          = r_state;
        w_err_code_next = r_err_code;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CONV_KICK;
            end
            S_CONV_KICK: begin
                w_next = S_CONV1_WAIT;
            end
            S_CONV1_WAIT: begin
                if (conv_done || fc_done) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_ORDER;
                end else if (conv1_done) begin
                    w_next = S_CONV2_WAIT;
                end else if (w_timeout) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_TIMEOUT;
                end
            end
            S_CONV2_WAIT: begin
                if (conv1_done || fc_done) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_ORDER;
                end else if (conv_done) begin
                    w_next = S_FC_KICK;
                end else if (w_timeout) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_TIMEOUT;
                end
            end
            S_FC_KICK: begin
                w_next = S_FC_WAIT;
            end
            S_FC_WAIT: begin
                if (conv1_done || conv_done) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_ORDER;
                end else if (fc_done) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next          = S_ERR;
                    w_err_code_next = ERR_TIMEOUT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                if (clear_err) begin
                    w_next          = S_IDLE;
                    w_err_code_next = ERR_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state       <= S_IDLE;
            r_err_code    <= ERR_NONE;
            r_wait_cnt    <= '0;
            r_cyc_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_last_cycles <= '0;
        end else begin
            r_state    <= w_next;
            r_err_code <= w_err_code_next;

            // Any state change clears it, so each wait state is
            // entered with a zero count.
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_in_wait) begin
                r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
            end

            if (r_state == S_IDLE) begin
                if (start) r_cyc_cnt <= '0;
            end else if (r_state != S_ERR) begin
                r_cyc_cnt <= w_cyc_inc;
            end

            if (r_state == S_FC_WAIT && w_next == S_DONE) begin
                r_last_cycles <= w_cyc_inc;
            end

            if (r_state == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign state             = r_state;
    assign conv_start        = (r_state == S_CONV_KICK);
    assign fc_start          = (r_state == S_FC_KICK);
    assign done              = (r_state == S_DONE);
    assign err               = (r_state == S_ERR);
    assign busy              = (r_state != S_IDLE);
    assign err_code          = r_err_code;
    assign frame_cnt         = r_frame_cnt;
    assign last_frame_cycles = r_last_cycles;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized frames against an arithmetic
// schedule model; a scoreboard checks every DUT output event.

module tb_layer_sequencer;

    localparam int T  = 8;
    localparam int FW = 2;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          srst, start, clear_err;
    logic          conv1_done, conv_done, fc_done;
    logic          conv_start, fc_start;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [2:0]    state;
    logic [FW-1:0] frame_cnt;
    logic [CW-1:0] last_frame_cycles;

    layer_sequencer #(
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_W(4),
        .CYC_W(CW),
        .FRAME_W(FW)
    ) dut (
        .clk(clk),
        .srst(srst),
        .start(start),
        .clear_err(clear_err),
        .conv_start(conv_start),
        .conv1_done(conv1_done),
        .conv_done(conv_done),
        .fc_start(fc_start),
        .fc_done(fc_done),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code),
        .state(state),
        .frame_cnt(frame_cnt),
        .last_frame_cycles(last_frame_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_CS, EV_FS, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
        int       code;
        int       fcnt;
        int       lfc;
    } ev_t;

    typedef struct packed {
        logic rst;
        logic st;
        logic c1;
        logic c2;
        logic fc;
        logic clr;
    } in_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   frames = 0;
    int   lfc_model = 0;
    bit   mon_en = 0;
    bit   prev_err = 0;
    int   held_code = 0;

    task automatic chk(input string name, input longint act,
                       input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d",
                     name, cyc, act, expv);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int at,
                           input int code, input int fcnt,
                           input int lfc);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.code = code;
        e.fcnt = fcnt;
        e.lfc  = lfc;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_%s", k.name()), 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("ev_kind", int'(k), int'(e.kind));
        chk($sformatf("%s_cycle", k.name()), cyc, e.at);
        if (k == EV_DONE) begin
            chk("done_frame_cnt", frame_cnt, e.fcnt);
            chk("done_last_cycles", last_frame_cycles, e.lfc);
        end
        if (k == EV_ERR) chk("err_code", err_code, e.code);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (conv_start && fc_start) chk("start_excl", 1, 0);
            if (conv_start) mon_ev(EV_CS);
            if (fc_start) mon_ev(EV_FS);
            if (done) mon_ev(EV_DONE);
            if (err && !prev_err) begin
                mon_ev(EV_ERR);
                held_code = int'(err_code);
            end else if (err) begin
                chk("err_code_held", err_code, held_code);
            end
            prev_err = err;
        end
    end

    function automatic in_t nz_start();
        in_t w = '0;
        w.st = ($urandom_range(3, 0) == 0);
        return w;
    endfunction

    function automatic in_t nz_done(input bit with_start);
        in_t w = '0;
        w.c1 = ($urandom_range(3, 0) == 0);
        w.c2 = ($urandom_range(3, 0) == 0);
        w.fc = ($urandom_range(3, 0) == 0);
        if (with_start) w.st = ($urandom_range(1, 0) == 0);
        return w;
    endfunction

    function automatic int pick_d(input int dsel);
        int r;
        if (dsel >= 0) return dsel;
        r = $urandom_range(9, 0);
        if (r < 6) return $urandom_range(3, 0);
        if (r < 8) return T - 1;
        return $urandom_range(T - 1, 0);
    endfunction

    task automatic apply(input in_t w);
        srst       = w.rst;
        start      = w.st;
        conv1_done = w.c1;
        conv_done  = w.c2;
        fc_done    = w.fc;
        clear_err  = w.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play(ref in_t s[$]);
        foreach (s[i]) begin
            apply(s[i]);
            tick();
        end
        apply('0);
    endtask

    // ERR dwell: a start that must be ignored, then clear_err.
    task automatic err_tail(ref in_t s[$]);
        in_t w;
        int  n;
        n = $urandom_range(4, 1);
        for (int i = 0; i < n; i++) begin
            w = nz_done(1'b1);
            if (i == 0) w.st = 1'b1;
            s.push_back(w);
        end
        w = '0;
        w.clr = 1'b1;
        s.push_back(w);
    endtask

    // mode: 0 clean, 1 timeout, 2 ordering, 3 reset; fs = stage
    task automatic run_frame(input int mode, input int fs,
                             input int dsel, input bit both);
        in_t s[$];
        in_t w;
        int  c0, idx, wst, dd, k;
        bit  ended;
        c0 = cyc;
        ended = 0;
        w = '0;
        w.st = 1'b1;
        s.push_back(w);
        s.push_back(nz_done(1'b1));
        push_ev(EV_CS, c0 + 1, 0, 0, 0);
        idx = 2;
        for (int st = 1; st <= 3 && !ended; st++) begin
            if (st == 3) begin
                s.push_back(nz_done(1'b1));
                push_ev(EV_FS, c0 + idx, 0, 0, 0);
                idx++;
            end
            wst = idx;
            if (mode == 1 && fs == st) begin
                for (int i = 0; i < T; i++) s.push_back(nz_start());
                push_ev(EV_ERR, c0 + wst + T, 1, 0, 0);
                err_tail(s);
                ended = 1;
            end else if (mode == 2 && fs == st) begin
                k = ($urandom_range(2, 0) == 0) ?
                    T - 1 : $urandom_range(T - 1, 0);
                for (int i = 0; i < k; i++) s.push_back(nz_start());
                w = nz_start();
                if ($urandom_range(1, 0) == 0)
                    w.c1 = (st != 1);
                else
                    w.fc = (st != 3);
                if (!w.c1 && !w.fc) w.c2 = 1'b1;
                if (both) begin
                    if (st == 1) w.c1 = 1'b1;
                    if (st == 2) w.c2 = 1'b1;
                    if (st == 3) w.fc = 1'b1;
                end
                s.push_back(w);
                push_ev(EV_ERR, c0 + wst + k + 1, 2, 0, 0);
                err_tail(s);
                ended = 1;
            end else if (mode == 3 && fs == st) begin
                k = $urandom_range(T - 1, 0);
                for (int i = 0; i < k; i++) s.push_back(nz_start());
                w = '0;
                w.rst = 1'b1;
                w.fc  = $urandom_range(1, 0);
                s.push_back(w);
                frames = 0;
                lfc_model = 0;
                ended = 1;
            end else begin
                dd = pick_d(dsel);
                for (int i = 0; i < dd; i++) s.push_back(nz_start());
                w = nz_start();
                if (st == 1) w.c1 = 1'b1;
                if (st == 2) w.c2 = 1'b1;
                if (st == 3) w.fc = 1'b1;
                s.push_back(w);
                idx = wst + dd + 1;
            end
        end
        if (!ended) begin
            push_ev(EV_DONE, c0 + idx, 0,
                    frames % (1 << FW), idx - 1);
            s.push_back(nz_done(1'b1));
            frames++;
            lfc_model = idx - 1;
        end
        play(s);
        chk("idle_state", state, 0);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
        chk("idle_err_code", err_code, 0);
        chk("idle_frame_cnt", frame_cnt, frames % (1 << FW));
        chk("idle_last_cycles", last_frame_cycles, lfc_model);
        k = $urandom_range(3, 0);
        for (int i = 0; i < k; i++) begin
            apply(nz_done(1'b0));
            tick();
        end
        apply('0);
    endtask

    initial begin
        int mode;
        apply('0);
        srst = 1'b1;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_fc_start", fc_start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_last_cycles", last_frame_cycles, 0);
        srst = 1'b0;
        mon_en = 1;
        tick();

        run_frame(0, 0, 0, 0);
        run_frame(1, 1, -1, 0);
        run_frame(0, 0, T - 1, 0);
        run_frame(2, 1, -1, 1);
        run_frame(3, 3, -1, 0);
        for (int i = 0; i < 5; i++) run_frame(0, 0, -1, 0);

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(9, 0);
            if (mode < 5)
                run_frame(0, 0, -1, 0);
            else if (mode < 7)
                run_frame(1, $urandom_range(3, 1), -1, 0);
            else if (mode < 9)
                run_frame(2, $urandom_range(3, 1), -1,
                          $urandom_range(1, 0));
            else
                run_frame(3, $urandom_range(3, 1), -1, 0);
        end

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
